// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - pre-add / multiply / accumulate pipeline producing one result per frame
// Stages: input regs -> product reg -> optional M reg -> accumulator/P; one global stall freezes all.
module dsp_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int D_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int MREG      = 1,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic                 inLast,
  input  logic [2:0]           opMode,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [B_WIDTH-1:0]   B,
  input  logic [D_WIDTH-1:0]   D,
  input  logic [ACC_WIDTH-1:0] C,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [ACC_WIDTH-1:0] P,
  output logic                 overflow
);

  localparam int PRE_W  = ((B_WIDTH > D_WIDTH) ? B_WIDTH : D_WIDTH) + 1;
  localparam int PROD_W = A_WIDTH + PRE_W;
  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic stall;
  logic advance;
  logic accept;

  assign stall   = outValid & ~outReady;
  assign advance = ~stall;
  assign inReady = ~stall;
  assign accept  = inValid & inReady;

  // frameStart marks that the next accepted beat opens a new frame and carries C
  logic                        frameStart;
  logic                        s0Valid;
  logic                        s0First;
  logic                        s0Last;
  logic [2:0]                  s0Op;
  logic signed [A_WIDTH-1:0]   s0A;
  logic signed [B_WIDTH-1:0]   s0B;
  logic signed [D_WIDTH-1:0]   s0D;
  logic signed [ACC_WIDTH-1:0] s0C;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frameStart <= 1'b1;
      s0Valid    <= 1'b0;
      s0First    <= 1'b0;
      s0Last     <= 1'b0;
      s0Op       <= '0;
      s0A        <= '0;
      s0B        <= '0;
      s0D        <= '0;
      s0C        <= '0;
    end else if (advance) begin
      s0Valid <= accept;
      if (accept) begin
        frameStart <= inLast;
        s0First    <= frameStart;
        s0Last     <= inLast;
        s0Op       <= opMode;
        s0A        <= A;
        s0B        <= B;
        s0D        <= D;
        if (frameStart) begin
          s0C <= C;
        end
      end
    end
  end

  logic signed [PRE_W-1:0]  preB;
  logic signed [PRE_W-1:0]  preD;
  logic signed [PRE_W-1:0]  preSum;
  logic signed [PROD_W-1:0] prodNext;

  always_comb begin
    preB = PRE_W'(s0B);
    preD = PRE_W'(s0D);
    case (s0Op[1:0])
      2'b01:   preSum = preD + preB;
      2'b10:   preSum = preD - preB;
      default: preSum = preB;
    endcase
    prodNext = PROD_W'(s0A) * PROD_W'(preSum);
  end

  logic                        s1Valid;
  logic                        s1First;
  logic                        s1Last;
  logic                        s1Sub;
  logic signed [ACC_WIDTH-1:0] s1C;
  logic signed [PROD_W-1:0]    s1Prod;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1Valid <= 1'b0;
      s1First <= 1'b0;
      s1Last  <= 1'b0;
      s1Sub   <= 1'b0;
      s1C     <= '0;
      s1Prod  <= '0;
    end else if (advance) begin
      s1Valid <= s0Valid;
      if (s0Valid) begin
        s1First <= s0First;
        s1Last  <= s0Last;
        s1Sub   <= s0Op[2];
        s1C     <= s0C;
        s1Prod  <= prodNext;
      end
    end
  end

  logic                        mValid;
  logic                        mFirst;
  logic                        mLast;
  logic                        mSub;
  logic signed [ACC_WIDTH-1:0] mC;
  logic signed [PROD_W-1:0]    mProd;

  generate
    if (MREG != 0) begin : gMreg
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          mValid <= 1'b0;
          mFirst <= 1'b0;
          mLast  <= 1'b0;
          mSub   <= 1'b0;
          mC     <= '0;
          mProd  <= '0;
        end else if (advance) begin
          mValid <= s1Valid;
          if (s1Valid) begin
            mFirst <= s1First;
            mLast  <= s1Last;
            mSub   <= s1Sub;
            mC     <= s1C;
            mProd  <= s1Prod;
          end
        end
      end
    end else begin : gNoMreg
      assign mValid = s1Valid;
      assign mFirst = s1First;
      assign mLast  = s1Last;
      assign mSub   = s1Sub;
      assign mC     = s1C;
      assign mProd  = s1Prod;
    end
  endgenerate

  // One guard bit above ACC_WIDTH is enough: both addends already fit in ACC_WIDTH
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] accBase;
  logic signed [ACC_WIDTH-1:0] accNext;
  logic signed [SUM_W-1:0]     sumFull;
  logic                        sumOvf;
  logic                        ovfSticky;
  logic                        ovfNext;

  always_comb begin
    accBase = mFirst ? mC : acc;
    if (mSub) begin
      sumFull = SUM_W'(accBase) - SUM_W'(mProd);
    end else begin
      sumFull = SUM_W'(accBase) + SUM_W'(mProd);
    end
    sumOvf = sumFull[SUM_W-1] ^ sumFull[SUM_W-2];
    if (sumOvf && (SATURATE != 0)) begin
      accNext = sumFull[SUM_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      accNext = sumFull[ACC_WIDTH-1:0];
    end
    ovfNext = sumOvf | (ovfSticky & ~mFirst);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc       <= '0;
      ovfSticky <= 1'b0;
      P         <= '0;
      overflow  <= 1'b0;
      outValid  <= 1'b0;
    end else if (advance) begin
      outValid <= mValid & mLast;
      if (mValid) begin
        acc       <= accNext;
        ovfSticky <= ovfNext;
        if (mLast) begin
          P        <= accNext;
          overflow <= ovfNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - directed-vector bench for dsp_mac_pipe across four parameter sets
module tb_dsp_mac_pipe;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inLast;
  logic [2:0]  opMode;
  logic [17:0] A;
  logic [17:0] B;
  logic [17:0] D;
  logic [47:0] C;
  logic        outReady;
  logic        auxValid;

  logic        inReady0, outValid0, overflow0;
  logic [47:0] P0;
  logic        inReadyM, outValidM, overflowM;
  logic [47:0] PM;
  logic        inReadyS, outValidS, overflowS;
  logic [39:0] PS;
  logic        inReadyW, outValidW, overflowW;
  logic [39:0] PW;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [48:0] q0[$];
  logic [48:0] qM[$];
  logic [48:0] qS[$];
  logic [48:0] qW[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Auxiliary instances accept exactly the beats the main instance accepts
  assign auxValid = inValid & inReady0;

  dsp_mac_pipe u0 (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady0), .inLast(inLast),
    .opMode(opMode), .A(A), .B(B), .D(D), .C(C),
    .outValid(outValid0), .outReady(outReady), .P(P0), .overflow(overflow0)
  );

  dsp_mac_pipe #(.MREG(0)) uM (
    .clk(clk), .rstN(rstN), .inValid(auxValid), .inReady(inReadyM), .inLast(inLast),
    .opMode(opMode), .A(A), .B(B), .D(D), .C(C),
    .outValid(outValidM), .outReady(1'b1), .P(PM), .overflow(overflowM)
  );

  dsp_mac_pipe #(.ACC_WIDTH(40), .SATURATE(1)) uS (
    .clk(clk), .rstN(rstN), .inValid(auxValid), .inReady(inReadyS), .inLast(inLast),
    .opMode(opMode), .A(A), .B(B), .D(D), .C(C[39:0]),
    .outValid(outValidS), .outReady(1'b1), .P(PS), .overflow(overflowS)
  );

  dsp_mac_pipe #(.ACC_WIDTH(40), .SATURATE(0)) uW (
    .clk(clk), .rstN(rstN), .inValid(auxValid), .inReady(inReadyW), .inLast(inLast),
    .opMode(opMode), .A(A), .B(B), .D(D), .C(C[39:0]),
    .outValid(outValidW), .outReady(1'b1), .P(PW), .overflow(overflowW)
  );

  always @(negedge clk) begin
    if (outValid0 && outReady) q0.push_back({overflow0, P0});
    if (outValidM) qM.push_back({overflowM, PM});
    if (outValidS) qS.push_back({overflowS, 8'h00, PS});
    if (outValidW) qW.push_back({overflowW, 8'h00, PW});
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clearQ();
    q0.delete();
    qM.delete();
    qS.delete();
    qW.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                          input logic [2:0] op, input logic [47:0] c, input logic last);
    int waitCnt;
    inValid = 1'b1;
    A       = a;
    B       = b;
    D       = d;
    opMode  = op;
    C       = c;
    inLast  = last;
    waitCnt = 0;
    @(negedge clk);
    while (!inReady0 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 50) checkVal("accept timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat0;
    int latM;
    int n;
    int start;
    logic drop;

    rstN = 1'b0; inValid = 1'b0; inLast = 1'b0; opMode = '0;
    A = '0; B = '0; D = '0; C = '0; outReady = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkVal("rst outValid0", outValid0, 1'b0);
    checkVal("rst P0", P0, 48'd0);
    checkVal("rst overflow0", overflow0, 1'b0);
    checkVal("rst inReady0", inReady0, 1'b1);
    checkVal("rst inReadyM", inReadyM, 1'b1);
    checkVal("rst inReadyS", inReadyS, 1'b1);
    checkVal("rst inReadyW", inReadyW, 1'b1);
    checkVal("rst outValidS", outValidS, 1'b0);
    rstN = 1'b1;
    idle(1);

    // one-beat frame, latency of both pipeline depths
    clearQ();
    sendBeat(18'd3, 18'd4, 18'd5, 3'b001, 48'd10, 1'b1);
    lat0 = -1; latM = -1; drop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (outValid0 && lat0 < 0) lat0 = i;
      if (outValidM && latM < 0) latM = i;
      if (i == 4) drop = outValid0;
    end
    idle(1);
    checkVal("latency mreg1", lat0, 3);
    checkVal("latency mreg0", latM, 2);
    checkVal("outValid drop", drop, 1'b0);
    checkVal("one-beat count", q0.size(), 1);
    if (q0.size() == 1) checkVal("one-beat P", q0[0], {1'b0, 48'd37});
    if (qM.size() == 1) checkVal("one-beat P mreg0", qM[0], {1'b0, 48'd37});

    // opMode 11 selects B alone
    clearQ();
    sendBeat(18'd3, 18'd4, 18'd100, 3'b011, 48'd0, 1'b1);
    idle(8);
    checkVal("op11 count", q0.size(), 1);
    if (q0.size() == 1) checkVal("op11 P", q0[0], {1'b0, 48'd12});

    // two back-to-back 4-beat frames, add then subtract
    clearQ();
    start = cyc;
    for (int i = 1; i <= 4; i++) sendBeat(18'(i), 18'd2, 18'd0, 3'b000, 48'd0, i == 4);
    for (int i = 1; i <= 4; i++) sendBeat(18'(i), 18'd2, 18'd0, 3'b100, 48'd100, i == 4);
    checkVal("b2b cycles", cyc - start, 8);
    idle(10);
    checkVal("b2b count", q0.size(), 2);
    if (q0.size() == 2) begin
      checkVal("b2b P add", q0[0], {1'b0, 48'd20});
      checkVal("b2b P sub", q0[1], {1'b0, 48'd80});
    end
    checkVal("b2b count mreg0", qM.size(), 2);
    if (qM.size() == 2) checkVal("b2b P sub mreg0", qM[1], {1'b0, 48'd80});

    // pre-adder D-B with negative A, no M register
    clearQ();
    sendBeat(18'h3FFFE, 18'd5, 18'd1, 3'b010, 48'd0, 1'b1);
    idle(8);
    checkVal("dminusb count mreg0", qM.size(), 1);
    if (qM.size() == 1) checkVal("dminusb P mreg0", qM[0], {1'b0, 48'd8});
    if (q0.size() == 1) checkVal("dminusb P", q0[0], {1'b0, 48'd8});

    // 20 products of 2^35: clamps / wraps in 40 bits, fits in 48; then a small frame
    clearQ();
    for (int i = 0; i < 20; i++) sendBeat(18'h20000, 18'h20000, 18'h20000, 3'b001, 48'd0, i == 19);
    sendBeat(18'd1, 18'd1, 18'd0, 3'b000, 48'd0, 1'b1);
    idle(10);
    checkVal("sat count", qS.size(), 2);
    if (qS.size() == 2) begin
      checkVal("sat P", qS[0], {1'b1, 8'h00, 40'h7FFFFFFFFF});
      checkVal("sat next frame", qS[1], {1'b0, 48'd1});
    end
    checkVal("wrap count", qW.size(), 2);
    if (qW.size() == 2) begin
      checkVal("wrap P", qW[0], {1'b1, 8'h00, 40'hA000000000});
      checkVal("wrap next frame", qW[1], {1'b0, 48'd1});
    end
    if (q0.size() == 2) checkVal("wide no-ovf P", q0[0], {1'b0, 48'hA000000000});

    // downstream stall while beats keep streaming
    clearQ();
    outReady = 1'b0;
    fork
      begin
        sendBeat(18'd1, 18'd1, 18'd0, 3'b000, 48'd5, 1'b1);
        sendBeat(18'd2, 18'd3, 18'd0, 3'b000, 48'd0, 1'b0);
        sendBeat(18'd2, 18'd3, 18'd0, 3'b000, 48'd0, 1'b0);
        sendBeat(18'd2, 18'd3, 18'd0, 3'b000, 48'd0, 1'b1);
        sendBeat(18'd1, 18'd1, 18'd0, 3'b000, 48'd1, 1'b1);
      end
      begin
        n = 0;
        while (!outValid0 && n < 20) begin
          @(negedge clk);
          n++;
        end
        checkVal("stall result", outValid0, 1'b1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkVal("stall inReady", inReady0, 1'b0);
          checkVal("stall P", P0, 48'd6);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    idle(12);
    checkVal("stall count", q0.size(), 3);
    if (q0.size() == 3) begin
      checkVal("stall P0", q0[0], {1'b0, 48'd6});
      checkVal("stall P1", q0[1], {1'b0, 48'd18});
      checkVal("stall P2", q0[2], {1'b0, 48'd2});
    end

    // asynchronous reset in the middle of a frame
    clearQ();
    sendBeat(18'd1, 18'd1, 18'd0, 3'b000, 48'd0, 1'b0);
    sendBeat(18'd1, 18'd1, 18'd0, 3'b000, 48'd0, 1'b0);
    #3;
    rstN = 1'b0;
    #1;
    checkVal("async rst outValid", outValid0, 1'b0);
    checkVal("async rst P", P0, 48'd0);
    checkVal("async rst overflow", overflow0, 1'b0);
    checkVal("async rst inReady", inReady0, 1'b1);
    checkVal("async rst P mreg0", PM, 48'd0);
    inValid = 1'b1; A = 18'd9; B = 18'd9; opMode = 3'b000; C = 48'd9; inLast = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    inValid = 1'b0;
    rstN = 1'b1;
    idle(1);
    sendBeat(18'd2, 18'd3, 18'd0, 3'b000, 48'd7, 1'b1);
    idle(8);
    checkVal("post-rst count", q0.size(), 1);
    if (q0.size() == 1) checkVal("post-rst P", q0[0], {1'b0, 48'd13});
    if (qM.size() == 1) checkVal("post-rst P mreg0", qM[0], {1'b0, 48'd13});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
